mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_if.sv | 36 +++
 rtl/mem_access_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Pipeline-side and bus-side signals of the memory access stage.
// slave: the stage itself; master: whoever drives the pipeline ops and models the bus.
interface mem_access_stage_if;
    logic        in_valid;
    logic        in_load;
    logic        in_store;
    logic [15:0] in_addr;
    logic [15:0] in_data;
    logic [2:0]  in_rd;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [2:0]  out_rd;
    logic        out_ready;
    logic [15:0] DataAddr;
    logic [15:0] BusIn;
    logic        ReadData;
    logic        WriteData;
    logic [15:0] BusOut;
    logic        DataDone;
    logic        timeout_err;

    modport slave (
        input  in_valid, in_load, in_store, in_addr, in_data, in_rd, out_ready,
               BusOut, DataDone,
        output in_ready, out_valid, out_data, out_rd, DataAddr, BusIn,
               ReadData, WriteData, timeout_err
    );

    modport master (
        output in_valid, in_load, in_store, in_addr, in_data, in_rd, out_ready,
               BusOut, DataDone,
        input  in_ready, out_valid, out_data, out_rd, DataAddr, BusIn,
               ReadData, WriteData, timeout_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: IDLE/REQ/HOLD FSM issuing one bus request per load/store.
// Optional bus timeout abort enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            Clock,
    input logic            Reset,
    mem_access_stage_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state;
    logic        op_load;
    logic        req_end;
    logic [15:0] fin_data;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;
    logic          expired;

    assign expired = !bus.DataDone && (cnt == CW'(TIMEOUT_CYCLES - 1));

    // A completion in the same cycle as expiry still counts as a normal completion.
    always_comb begin
        req_end  = bus.DataDone;
        fin_data = bus.BusOut;
        if (expired) begin
            req_end  = 1'b1;
            fin_data = 16'hDEAD;
        end
    end
`else
    always_comb begin
        req_end  = bus.DataDone;
        fin_data = bus.BusOut;
    end

    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            op_load       <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 16'h0000;
            bus.out_rd    <= 3'd0;
            bus.DataAddr  <= 16'h0000;
            bus.BusIn     <= 16'h0000;
            bus.ReadData  <= 1'b0;
            bus.WriteData <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt             <= '0;
            bus.timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        bus.out_rd   <= bus.in_rd;
                        op_load      <= bus.in_load;
                        if (bus.in_load || bus.in_store) begin
                            // Load wins when both op bits are set.
                            state         <= REQ;
                            bus.DataAddr  <= bus.in_addr;
                            bus.BusIn     <= bus.in_data;
                            bus.ReadData  <= bus.in_load;
                            bus.WriteData <= !bus.in_load;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            cnt <= '0;
`endif
                        end else begin
                            state         <= HOLD;
                            bus.out_data  <= bus.in_data;
                            bus.out_valid <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (req_end) begin
                        bus.ReadData  <= 1'b0;
                        bus.WriteData <= 1'b0;
                        if (op_load) begin
                            state         <= HOLD;
                            bus.out_data  <= fin_data;
                            bus.out_valid <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            bus.in_ready <= 1'b1;
                        end
`ifdef MEM_ACCESS_TIMEOUT_EN
                        if (expired) bus.timeout_err <= 1'b1;
`endif
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end

                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.ReadData  <= 1'b0;
                    bus.WriteData <= 1'b0;
                end
            endcase
        end
    end

endmodule
